// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline-stage register with a two-entry skid buffer.
// Carries a DATA_W-bit payload plus a halt flag under valid/ready handshaking.
// in_ready is derived from registered state only, so it has no combinational
// path from out_ready. Supports flush, stall and a sticky halt.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
`ifdef PIPE_STAGE_STATS_EN
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  xfer_count,
`endif
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic              main_halt_reg, main_halt_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic              skid_halt_reg, skid_halt_next;
  logic              halted_reg, halted_next;
  logic              accept, consume;

  assign in_ready  = (state_reg != FULL) & ~halted_reg;
  assign out_valid = (state_reg != EMPTY) & ~halted_reg;
  assign out_data  = main_data_reg;
  assign out_halt  = main_halt_reg;
  assign halted    = halted_reg;
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready & ~stall & ~flush;

  // Occupancy follows the registered state; illegal encodings read as empty.
  always_comb begin
    occupancy = 2'd0;
    case (state_reg)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and entry movement: flush, then halt consumption, then normal flow.
  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_halt_next = main_halt_reg;
    skid_data_next = skid_data_reg;
    skid_halt_next = skid_halt_reg;
    halted_next    = halted_reg;
    if (flush) begin
      // Entries are abandoned; main payload is kept so out_data holds its value.
      state_next = EMPTY;
    end else if (consume && main_halt_reg) begin
      // Halt token leaves the stage once; anything behind it is discarded.
      halted_next = 1'b1;
      state_next  = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next     = ONE;
            main_data_next = in_data;
            main_halt_next = in_halt;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data_next = in_data;
            main_halt_next = in_halt;
          end else if (accept) begin
            state_next     = FULL;
            skid_data_next = in_data;
            skid_halt_next = in_halt;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_next     = ONE;
            main_data_next = skid_data_reg;
            main_halt_next = skid_halt_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State and entry registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_halt_reg <= 1'b0;
      skid_data_reg <= '0;
      skid_halt_reg <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_halt_reg <= main_halt_next;
      skid_data_reg <= skid_data_next;
      skid_halt_reg <= skid_halt_next;
      halted_reg    <= halted_next;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cycles_reg, flush_count_reg, xfer_count_reg;

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
  assign xfer_count   = xfer_count_reg;

  // Saturating statistics counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
      xfer_count_reg   <= '0;
    end else begin
      if (out_valid && (stall || !out_ready) && stall_cycles_reg != '1)
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      if (flush && occupancy != 2'd0 && flush_count_reg != '1)
        flush_count_reg <= flush_count_reg + 1'b1;
      if (consume && xfer_count_reg != '1)
        xfer_count_reg <= xfer_count_reg + 1'b1;
    end
  end
`endif

endmodule
